// File: rtl/time_display.sv
// rtl/time_display.sv - chess-clock time display: binary->BCD converter plus 8-digit 7-segment scanner.
// Optional separator blinking for the active player is enabled with TIME_DISPLAY_BLINK_EN.
module time_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [6:0] min_a,
    input  logic [5:0] sec_a,
    input  logic [6:0] min_b,
    input  logic [5:0] sec_b,
    input  logic       turn,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] an,
    output logic       busy
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("time_display: REFRESH_DIV and BLINK_DIV must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [27:0]     sh_q, sh_d;
    logic [7:0]      bcd_q, bcd_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      fld_q, fld_d;
    logic [3:0][7:0] res_q, res_d;
    logic            turn_cap_q, turn_cap_d;
    logic [31:0]     disp_q, disp_d;
    logic            turn_disp_q, turn_disp_d;
    logic [RW-1:0]   ref_cnt_q, ref_cnt_d;
    logic            scan_on_q, scan_on_d;
    logic [2:0]      idx_q, idx_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [7:0]      an_q, an_d;
    logic [3:0]      digit;
    logic [7:0]      adj;
    logic [7:0]      nxt;

    function automatic logic [6:0] clamp_min(input logic [6:0] m);
        return (m > 7'd99) ? 7'd99 : m;
    endfunction

    function automatic logic [6:0] clamp_sec(input logic [5:0] s);
        return {1'b0, (s > 6'd59) ? 6'd59 : s};
    endfunction

    function automatic logic [7:0] add3(input logic [7:0] v);
        logic [3:0] hi, lo;
        hi = (v[7:4] >= 4'd5) ? v[7:4] + 4'd3 : v[7:4];
        lo = (v[3:0] >= 4'd5) ? v[3:0] + 4'd3 : v[3:0];
        return {hi, lo};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

`ifdef TIME_DISPLAY_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blink_d     = blink_q;
        if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`endif

    // Converter: one field at a time, 7 shift-add-3 steps each, min_a first.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        bcd_d       = bcd_q;
        bit_d       = bit_q;
        fld_d       = fld_q;
        res_d       = res_q;
        turn_cap_d  = turn_cap_q;
        disp_d      = disp_q;
        turn_disp_d = turn_disp_q;
        adj         = add3(bcd_q);
        nxt         = 8'({adj, sh_q[27]});
        case (state_q)
            IDLE: begin
                if (load) begin
                    sh_d       = {clamp_min(min_a), clamp_sec(sec_a), clamp_min(min_b), clamp_sec(sec_b)};
                    turn_cap_d = turn;
                    bcd_d      = '0;
                    bit_d      = '0;
                    fld_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                sh_d = {sh_q[26:0], 1'b0};
                if (bit_q == 3'd6) begin
                    res_d[fld_q] = nxt;
                    bcd_d        = '0;
                    bit_d        = '0;
                    fld_d        = fld_q + 2'd1;
                    if (fld_q == 2'd3) state_d = COMMIT;
                end else begin
                    bcd_d = nxt;
                    bit_d = bit_q + 3'd1;
                end
            end
            COMMIT: begin
                disp_d      = {res_q[0], res_q[1], res_q[2], res_q[3]};
                turn_disp_d = turn_cap_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scanner: nothing lit until the first prescaler wrap, which shows digit 0.
    always_comb begin
        ref_cnt_d = ref_cnt_q + 1'b1;
        scan_on_d = scan_on_q;
        idx_d     = idx_q;
        if (ref_cnt_q == RW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            if (scan_on_q) idx_d = idx_q + 3'd1;
            else           scan_on_d = 1'b1;
        end
        digit = disp_q[{idx_d, 2'b00} +: 4];
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        an_d  = 8'hFF;
        if (scan_on_d) begin
            seg_d = seg_code(digit);
            an_d  = ~(8'b1 << idx_d);
            if (idx_d == 3'd2 || idx_d == 3'd6) begin
`ifdef TIME_DISPLAY_BLINK_EN
                if (idx_d == (turn_disp_q ? 3'd2 : 3'd6)) dp_d = ~blink_d;
                else                                     dp_d = 1'b0;
`else
                dp_d = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            bcd_q       <= '0;
            bit_q       <= '0;
            fld_q       <= '0;
            res_q       <= '0;
            turn_cap_q  <= 1'b0;
            disp_q      <= '0;
            turn_disp_q <= 1'b0;
            ref_cnt_q   <= '0;
            scan_on_q   <= 1'b0;
            idx_q       <= '0;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
            an_q        <= 8'hFF;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            bcd_q       <= bcd_d;
            bit_q       <= bit_d;
            fld_q       <= fld_d;
            res_q       <= res_d;
            turn_cap_q  <= turn_cap_d;
            disp_q      <= disp_d;
            turn_disp_q <= turn_disp_d;
            ref_cnt_q   <= ref_cnt_d;
            scan_on_q   <= scan_on_d;
            idx_q       <= idx_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg  = seg_q;
    assign dp   = dp_q;
    assign an   = an_q;
    assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_time_display.sv
// tb/tb_time_display.sv - scoreboard bench for time_display (REFRESH_DIV=4, BLINK_DIV=16).
module tb_time_display;
    logic       clk = 1'b0;
    logic       reset, load, turn;
    logic [6:0] min_a, min_b;
    logic [5:0] sec_a, sec_b;
    logic [6:0] seg;
    logic       dp, busy;
    logic [7:0] an;

    time_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
        .clk(clk), .reset(reset), .load(load),
        .min_a(min_a), .sec_a(sec_a), .min_b(min_b), .sec_b(sec_b),
        .turn(turn), .seg(seg), .dp(dp), .an(an), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bcd;
        logic [7:0]  blen;
        logic        trn;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    bit          mon_busy = 1'b0;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    function automatic logic exp_dp(input int idx, input logic trn, input int unsigned c);
        if (idx != 2 && idx != 6) return 1'b1;
`ifdef TIME_DISPLAY_BLINK_EN
        if (idx == (trn ? 2 : 6)) return ~c[4];
`endif
        return 1'b0;
    endfunction

    // Monitor: a falling busy marks a finished conversion; verify its length and one full scan.
    initial begin
        int         blen;
        logic       prev;
        exp_t       e;
        logic [7:0] seen;
        int         idx;
        blen = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) blen++;
            else if (prev) begin
                mon_busy = 1'b1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got busy fall, expected none");
                end else begin
                    e = sb_q.pop_front();
                    check("busy_len", blen, {24'd0, e.blen});
                    seen = '0;
                    repeat (2) @(negedge clk);
                    for (int k = 0; k < 48; k++) begin
                        @(negedge clk);
                        idx = -1;
                        for (int i = 0; i < 8; i++) if (an == ~(8'b1 << i)) idx = i;
                        if (idx >= 0) begin
                            seen[idx] = 1'b1;
                            check($sformatf("seg_d%0d", idx), {25'd0, seg}, {25'd0, seg_of(e.bcd[4*idx +: 4])});
                            check($sformatf("dp_d%0d", idx), {31'd0, dp}, {31'd0, exp_dp(idx, e.trn, cyc)});
                        end
                    end
                    check("all_digits", {24'd0, seen}, 32'hFF);
                end
                blen = 0;
                mon_busy = 1'b0;
            end
            prev = busy;
        end
    end

    task automatic pulse_load(input logic [6:0] ma, input logic [5:0] sa,
                              input logic [6:0] mb, input logic [5:0] sb, input logic t);
        min_a = ma; sec_a = sa; min_b = mb; sec_b = sb; turn = t;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] ma, input logic [5:0] sa,
                           input logic [6:0] mb, input logic [5:0] sb, input logic t);
        @(negedge clk);
        pulse_load(ma, sa, mb, sb, t);
    endtask

    task automatic wait_idle();
        int i;
        i = 0;
        while (i < 300 && (sb_q.size() != 0 || busy || mon_busy)) begin
            @(negedge clk);
            i++;
        end
        if (i >= 300) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got timeout, expected completion within 300 cycles");
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_an;
        reset = 1'b1; load = 1'b0; turn = 1'b0;
        min_a = '0; sec_a = '0; min_b = '0; sec_b = '0;
        repeat (3) @(negedge clk);
        check("rst_seg", {25'd0, seg}, 32'h7F);
        check("rst_dp", {31'd0, dp}, 32'h1);
        check("rst_an", {24'd0, an}, 32'hFF);
        check("rst_busy", {31'd0, busy}, 32'h0);
        reset = 1'b0;

        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_an = (k < 4) ? 8'hFF : ~(8'b1 << (((k - 4) / 4) % 8));
            check($sformatf("scan_an_k%0d", k), {24'd0, an}, {24'd0, exp_an});
            check($sformatf("scan_seg_k%0d", k), {25'd0, seg}, (k < 4) ? 32'h7F : 32'h40);
        end

        sb_q.push_back('{bcd: 32'h1234_0509, blen: 8'd29, trn: 1'b0});
        do_load(7'd12, 6'd34, 7'd5, 6'd9, 1'b0);
        wait_idle();

        sb_q.push_back('{bcd: 32'h9959_0000, blen: 8'd29, trn: 1'b1});
        do_load(7'd120, 6'd63, 7'd0, 6'd0, 1'b1);
        wait_idle();

        sb_q.push_back('{bcd: 32'h4506_0708, blen: 8'd29, trn: 1'b0});
        do_load(7'd45, 6'd6, 7'd7, 6'd8, 1'b0);
        repeat (9) @(negedge clk);
        pulse_load(7'd11, 6'd22, 7'd33, 6'd44, 1'b1);
        wait_idle();

        sb_q.push_back('{bcd: 32'h0000_0000, blen: 8'd15, trn: 1'b0});
        do_load(7'd30, 6'd30, 7'd30, 6'd30, 1'b1);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'h0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end
endmodule
